// File: rtl/mdu_iter.sv
// mdu_iter: iterative 32x32 multiply / divide unit (MULTU, MULT, DIVU, DIV) for the EXE stage.
// Latency: start sampled at E0, busy E0..E32, HI/LO + one-cycle done at E32; 34-cycle issue interval.
// Backpressure: none; start is ignored while busy/done, flush aborts to IDLE with HI/LO unchanged.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   start   launch request, accepted only in IDLE and only without flush
//   ALU2Op  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B    rs / rt operands, sampled only on the accepting edge
//   flush   synchronous abort
//   busy    operation in flight
//   done    one-cycle pulse, HI/LO valid
//   HI, LO  product[63:32]/[31:0] or remainder/quotient
module mdu_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  ALU2Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        res_neg_q, res_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [31:0] opb_q, opb_d;     // multiplicand (mul) or divisor (div) magnitude
  logic [63:0] acc_q, acc_d;     // mul: {partial hi, multiplier/low}, div: {remainder, dividend/quotient}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operand magnitudes for the launch edge.
  logic        op_signed;
  logic [31:0] a_abs, b_abs;

  assign op_signed = ALU2Op[0];
  assign a_abs     = (op_signed && A[31]) ? (32'd0 - A) : A;
  assign b_abs     = (op_signed && B[31]) ? (32'd0 - B) : B;

  // One shift-add multiply step: add multiplicand when the current multiplier bit is set,
  // then shift the whole 64-bit accumulator right, keeping the carry.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // One restoring divide step. The partial remainder stays below the divisor, so the shifted
  // trial value is below twice the divisor and bit 32 of the 33-bit difference is the borrow.
  // With a zero divisor the trial never borrows: quotient all ones, remainder ends as |A|.
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ok;
  logic [63:0] div_next;

  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ok    = ~div_diff[32];
  assign div_next  = {(div_ok ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], div_ok};

  // Sign correction applied to the value produced by the final iteration.
  logic [63:0] step_res;
  logic [63:0] mul_fixed;
  logic [31:0] quo_fixed, rem_fixed;

  assign step_res  = is_div_q ? div_next : mul_next;
  assign mul_fixed = res_neg_q ? (64'd0 - step_res) : step_res;
  assign quo_fixed = res_neg_q ? (32'd0 - step_res[31:0]) : step_res[31:0];
  assign rem_fixed = rem_neg_q ? (32'd0 - step_res[63:32]) : step_res[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_RUN;
            cnt_d     = 5'd0;
            is_div_d  = ALU2Op[1];
            res_neg_d = op_signed & (A[31] ^ B[31]);
            rem_neg_d = op_signed & A[31];
            if (ALU2Op[1]) begin
              acc_d = {32'd0, a_abs};
              opb_d = b_abs;
            end else begin
              acc_d = {32'd0, b_abs};
              opb_d = a_abs;
            end
          end
        end
        S_RUN: begin
          acc_d = step_res;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_DONE;
            if (is_div_q) begin
              hi_d = rem_fixed;
              lo_d = quo_fixed;
            end else begin
              hi_d = mul_fixed[63:32];
              lo_d = mul_fixed[31:0];
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      opb_q     <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
